wb_port_arbiter: RTL

- Shares the single register-file write port between two requesters: the pipeline writeback stage, and a multi-cycle multiply/divide unit (MDU) returning GPR results out of band.
- The pipeline always has priority. The MDU is granted idle write slots.
- A starvation counter raises a stall request so pipeline control injects a bubble into MEM/WB and frees a slot.
- Sits between the writeback stage and the register file.

---
 rtl/wb_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and the MDU.
// Optional statistics outputs are enabled with the WB_ARB_STATS_EN macro.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_wreg,
    input  logic [4:0]  wb_destR,
    input  logic [31:0] wb_dest,
    input  logic        mdu_req,
    input  logic [4:0]  mdu_destR,
    input  logic [31:0] mdu_data,
    output logic        mdu_ack,
    output logic        mdu_drop,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0] stat_stalls,
    output logic [15:0] stat_drops
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;

    logic pw;
    logic mr;
    logic drop;
    logic grant;
    logic consumed;

    logic        rf_we_nx;
    logic [4:0]  rf_waddr_nx;
    logic [31:0] rf_wdata_nx;

    // Qualify both requesters and resolve who owns this cycle's slot.
    always_comb begin
        pw       = wb_wreg && (wb_destR != 5'd0);
        mr       = mdu_req && !mdu_ack;
        drop     = pw && mr && (wb_destR == mdu_destR);
        grant    = !pw && mr;
        consumed = drop || grant;
        cnt_inc  = cnt + ONE;
    end

    // Select the next write-port contents; the pipeline always wins.
    always_comb begin
        rf_we_nx    = 1'b0;
        rf_waddr_nx = rf_waddr;
        rf_wdata_nx = rf_wdata;
        if (pw) begin
            rf_we_nx    = 1'b1;
            rf_waddr_nx = wb_destR;
            rf_wdata_nx = wb_dest;
        end else if (mr) begin
            rf_we_nx    = (mdu_destR != 5'd0);
            rf_waddr_nx = mdu_destR;
            rf_wdata_nx = mdu_data;
        end
    end

    // Starvation FSM: count unserved MDU cycles and escalate to a stall.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (mr && !consumed) begin
                    cnt_nx   = ONE;
                    state_nx = (ONE == LIMIT) ? STALL : WAIT;
                end
            end
            WAIT: begin
                if (!mr || consumed) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == LIMIT) begin
                        state_nx = STALL;
                    end
                end
            end
            STALL: begin
                if (!mr || consumed) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Registered write port, handshake pulses and stall request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            mdu_ack   <= 1'b0;
            mdu_drop  <= 1'b0;
            stall_req <= 1'b0;
        end else begin
            rf_we     <= rf_we_nx;
            rf_waddr  <= rf_waddr_nx;
            rf_wdata  <= rf_wdata_nx;
            mdu_ack   <= consumed;
            mdu_drop  <= drop;
            stall_req <= (state_nx == STALL);
        end
    end

`ifdef WB_ARB_STATS_EN
    logic stall_entry;

    // A stall episode starts when the FSM moves into STALL from elsewhere.
    always_comb begin
        stall_entry = (state_nx == STALL) && (state != STALL);
    end

    // Saturating event counters for stall episodes and WAW drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stalls <= 16'd0;
            stat_drops  <= 16'd0;
        end else begin
            if (stall_entry && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
            if (drop && (stat_drops != 16'hFFFF)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end
`endif

endmodule
